// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter that shares one AXI4 slave write port among several
// write masters. One burst is in flight at a time. The owner keeps the grant
// from AW acceptance through its last W beat and the B response. s_wlast is
// derived from the accepted awlen, and any disagreement with the master's own
// wlast raises a sticky protocol_err.
//
// state | meaning
// IDLE  | no owner; pick the next requester round-robin from rr_ptr
// ADDR  | owner's AW channel routed to the slave, waiting for the handshake
// DATA  | owner's W channel routed; beats_left counts the remaining beats
// RESP  | slave B channel routed back to the owner; release on the handshake
module axi4_write_arbiter #(
  parameter int NO_OF_MASTERS = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  // master-side AW
  input  logic [NO_OF_MASTERS-1:0]              m_awvalid,
  output logic [NO_OF_MASTERS-1:0]              m_awready,
  input  logic [NO_OF_MASTERS*ID_WIDTH-1:0]     m_awid,
  input  logic [NO_OF_MASTERS*ADDRESS_WIDTH-1:0] m_awaddr,
  input  logic [NO_OF_MASTERS*8-1:0]            m_awlen,
  input  logic [NO_OF_MASTERS*3-1:0]            m_awsize,
  input  logic [NO_OF_MASTERS*2-1:0]            m_awburst,
  // master-side W
  input  logic [NO_OF_MASTERS-1:0]              m_wvalid,
  output logic [NO_OF_MASTERS-1:0]              m_wready,
  input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NO_OF_MASTERS*(DATA_WIDTH/8)-1:0] m_wstrb,
  input  logic [NO_OF_MASTERS-1:0]              m_wlast,
  // master-side B
  output logic [NO_OF_MASTERS-1:0]              m_bvalid,
  input  logic [NO_OF_MASTERS-1:0]              m_bready,
  output logic [ID_WIDTH-1:0]                   m_bid,
  output logic [1:0]                            m_bresp,
  // slave-side AW
  output logic                                  s_awvalid,
  input  logic                                  s_awready,
  output logic [ID_WIDTH-1:0]                   s_awid,
  output logic [ADDRESS_WIDTH-1:0]              s_awaddr,
  output logic [7:0]                            s_awlen,
  output logic [2:0]                            s_awsize,
  output logic [1:0]                            s_awburst,
  // slave-side W
  output logic                                  s_wvalid,
  input  logic                                  s_wready,
  output logic [DATA_WIDTH-1:0]                 s_wdata,
  output logic [DATA_WIDTH/8-1:0]               s_wstrb,
  output logic                                  s_wlast,
  // slave-side B
  input  logic                                  s_bvalid,
  output logic                                  s_bready,
  input  logic [ID_WIDTH-1:0]                   s_bid,
  input  logic [1:0]                            s_bresp,
  // status
  output logic [NO_OF_MASTERS-1:0]              grant,
  output logic                                  protocol_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;
  localparam logic [IDX_W:0]   NUM_M    = (IDX_W+1)'(NO_OF_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_OF_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                   state, state_nxt;
  logic [NO_OF_MASTERS-1:0] grant_q, grant_nxt;
  logic [IDX_W-1:0]         gidx, gidx_nxt;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic [7:0]               beats_left, beats_left_nxt;
  logic                     perr_q, perr_nxt;

  logic                     win_found;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W:0]           cand;
  logic                     wlast_gen;

  logic                     sel_awvalid;
  logic [ID_WIDTH-1:0]      sel_awid;
  logic [ADDRESS_WIDTH-1:0] sel_awaddr;
  logic [7:0]               sel_awlen;
  logic [2:0]               sel_awsize;
  logic [1:0]               sel_awburst;
  logic                     sel_wvalid;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic [STRB_WIDTH-1:0]    sel_wstrb;
  logic                     sel_wlast;
  logic                     sel_bready;

  assign grant        = grant_q;
  assign protocol_err = perr_q;
  assign wlast_gen    = (beats_left == 8'd0);

  // AND-OR mux of the owner's signals; an all-zero grant yields all zeros.
  always_comb begin
    sel_awvalid = 1'b0;
    sel_awid    = '0;
    sel_awaddr  = '0;
    sel_awlen   = '0;
    sel_awsize  = '0;
    sel_awburst = '0;
    sel_wvalid  = 1'b0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    sel_wlast   = 1'b0;
    sel_bready  = 1'b0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      if (grant_q[i]) begin
        sel_awvalid = sel_awvalid | m_awvalid[i];
        sel_awid    = sel_awid    | m_awid[i*ID_WIDTH +: ID_WIDTH];
        sel_awaddr  = sel_awaddr  | m_awaddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_awlen   = sel_awlen   | m_awlen[i*8 +: 8];
        sel_awsize  = sel_awsize  | m_awsize[i*3 +: 3];
        sel_awburst = sel_awburst | m_awburst[i*2 +: 2];
        sel_wvalid  = sel_wvalid  | m_wvalid[i];
        sel_wdata   = sel_wdata   | m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb   = sel_wstrb   | m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
        sel_wlast   = sel_wlast   | m_wlast[i];
        sel_bready  = sel_bready  | m_bready[i];
      end
    end
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping at N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NO_OF_MASTERS; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= NUM_M) cand = cand - NUM_M;
      if (!win_found && m_awvalid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and channel routing; every channel is closed outside its state.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    gidx_nxt       = gidx;
    rr_ptr_nxt     = rr_ptr;
    beats_left_nxt = beats_left;
    perr_nxt       = perr_q;
    m_awready      = '0;
    m_wready       = '0;
    m_bvalid       = '0;
    m_bid          = '0;
    m_bresp        = '0;
    s_awvalid      = 1'b0;
    s_awid         = '0;
    s_awaddr       = '0;
    s_awlen        = '0;
    s_awsize       = '0;
    s_awburst      = '0;
    s_wvalid       = 1'b0;
    s_wdata        = '0;
    s_wstrb        = '0;
    s_wlast        = 1'b0;
    s_bready       = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt = NO_OF_MASTERS'(1) << win_idx;
          gidx_nxt  = win_idx;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        s_awvalid       = sel_awvalid;
        s_awid          = sel_awid;
        s_awaddr        = sel_awaddr;
        s_awlen         = sel_awlen;
        s_awsize        = sel_awsize;
        s_awburst       = sel_awburst;
        m_awready[gidx] = s_awready;
        if (sel_awvalid && s_awready) begin
          beats_left_nxt = sel_awlen;
          state_nxt      = DATA;
        end
      end
      DATA: begin
        s_wvalid       = sel_wvalid;
        s_wdata        = sel_wdata;
        s_wstrb        = sel_wstrb;
        s_wlast        = wlast_gen;
        m_wready[gidx] = s_wready;
        if (sel_wvalid && s_wready) begin
          if (sel_wlast != wlast_gen) perr_nxt = 1'b1;
          if (wlast_gen) state_nxt = RESP;
          else           beats_left_nxt = beats_left - 8'd1;
        end
      end
      RESP: begin
        m_bvalid[gidx] = s_bvalid;
        m_bid          = s_bid;
        m_bresp        = s_bresp;
        s_bready       = sel_bready;
        if (s_bvalid && sel_bready) begin
          rr_ptr_nxt = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
          grant_nxt  = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant, pointer, beat counter and sticky error registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q    <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      beats_left <= '0;
      perr_q     <= 1'b0;
    end else begin
      grant_q    <= grant_nxt;
      gidx       <= gidx_nxt;
      rr_ptr     <= rr_ptr_nxt;
      beats_left <= beats_left_nxt;
      perr_q     <= perr_nxt;
    end
  end

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Directed bench for axi4_write_arbiter with two masters.
module tb_axi4_write_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  m_awvalid, m_awready;
  logic [7:0]  m_awid;
  logic [63:0] m_awaddr;
  logic [15:0] m_awlen;
  logic [5:0]  m_awsize;
  logic [3:0]  m_awburst;
  logic [1:0]  m_wvalid, m_wready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wlast;
  logic [1:0]  m_bvalid, m_bready;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        s_awvalid, s_awready;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic [1:0]  grant;
  logic        protocol_err;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  axi4_write_arbiter #(
    .NO_OF_MASTERS(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .grant(grant), .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  logic [1:0] fair_exp [12];
  int hs;
  int nlast;

  initial begin
    fair_exp = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00,
                 2'b01, 2'b01, 2'b01, 2'b00};
    aresetn = 1'b0;
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0;
    m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;

    // reset state
    step(); step();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_perr", protocol_err, 1'b0);
    chk("rst_s_awvalid", s_awvalid, 1'b0);
    chk("rst_s_wvalid", s_wvalid, 1'b0);
    chk("rst_s_bready", s_bready, 1'b0);
    chk("rst_m_awready", m_awready, 2'b00);
    aresetn = 1'b1;

    // single burst from m0: awaddr 0x100, awlen 3
    step();
    m_awvalid = 2'b01; m_awaddr[31:0] = 32'h100; m_awlen[7:0] = 8'd3;
    m_awid[3:0] = 4'h5; m_awsize[2:0] = 3'd2; m_awburst[1:0] = 2'd1;
    m_wstrb[3:0] = 4'hF; m_bready = 2'b01;
    #1;
    chk("single_grant_pre", grant, 2'b00);
    step();
    #1;
    chk("single_grant", grant, 2'b01);
    chk("single_s_awvalid", s_awvalid, 1'b1);
    chk("single_s_awaddr", s_awaddr, 32'h100);
    chk("single_s_awlen", s_awlen, 8'd3);
    chk("single_s_awid", s_awid, 4'h5);
    chk("single_m_awready", m_awready, 2'b01);
    step();
    m_awvalid = 2'b00;
    #1;
    chk("single_s_awvalid_off", s_awvalid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      m_wvalid = 2'b01;
      m_wdata[31:0] = 32'h11 * (b + 1);
      m_wlast = {1'b0, (b == 3)};
      #1;
      chk("single_s_wvalid", s_wvalid, 1'b1);
      chk("single_s_wdata", s_wdata, 32'h11 * (b + 1));
      chk("single_s_wlast", s_wlast, (b == 3));
      chk("single_m_wready", m_wready, 2'b01);
      step();
    end
    m_wvalid = 2'b00; m_wlast = 2'b00;
    s_bvalid = 1'b1; s_bid = 4'h5; s_bresp = 2'b00;
    #1;
    chk("single_m_bvalid", m_bvalid, 2'b01);
    chk("single_m_bid", m_bid, 4'h5);
    chk("single_m_bresp", m_bresp, 2'b00);
    chk("single_s_bready", s_bready, 1'b1);
    step();
    s_bvalid = 1'b0;
    #1;
    chk("single_idle_grant", grant, 2'b00);
    chk("single_perr", protocol_err, 1'b0);

    // fairness: both masters request continuously, awlen 0
    aresetn = 1'b0;
    step();
    m_awvalid = 2'b11; m_awlen = 16'h0000;
    m_wvalid = 2'b11; m_wlast = 2'b11; m_bready = 2'b11; s_bvalid = 1'b1;
    aresetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      #1;
      chk($sformatf("fair_grant_%0d", k), grant, fair_exp[k]);
    end
    chk("fair_perr", protocol_err, 1'b0);
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b0; m_bready = '0;

    // early wlast from m0 on beat 2 of a 4-beat burst
    m_awvalid = 2'b01; m_awlen[7:0] = 8'd3;
    step();
    #1;
    chk("early_grant", grant, 2'b01);
    step();
    m_awvalid = 2'b00;
    for (int b = 0; b < 4; b++) begin
      m_wvalid = 2'b01;
      m_wlast = {1'b0, (b == 1)};
      #1;
      chk("early_s_wlast", s_wlast, (b == 3));
      chk("early_perr", protocol_err, (b >= 2));
      step();
    end
    m_wvalid = '0; m_wlast = '0;
    s_bvalid = 1'b1; m_bready = 2'b01;
    step();
    s_bvalid = 1'b0;
    #1;
    chk("early_perr_sticky", protocol_err, 1'b1);
    chk("early_idle_grant", grant, 2'b00);

    // max burst from m1: awlen 255 with s_wready toggling
    m_awvalid = 2'b10; m_awlen[15:8] = 8'd255; m_bready = 2'b10;
    step();
    #1;
    chk("max_grant", grant, 2'b10);
    step();
    m_awvalid = 2'b00;
    hs = 0; nlast = 0;
    for (int cyc = 0; cyc < 530; cyc++) begin
      s_wready = cyc[0];
      m_wvalid = 2'b10;
      m_wlast = {(hs == 255), 1'b0};
      #1;
      if (s_wvalid && s_wready) begin
        if (hs == 0 || hs >= 254)
          chk($sformatf("max_s_wlast_%0d", hs), s_wlast, (hs == 255));
        else
          chk("max_s_wlast", s_wlast, 1'b0);
        if (s_wlast) nlast++;
        hs++;
      end
      step();
    end
    chk("max_handshakes", hs, 256);
    chk("max_wlast_count", nlast, 1);
    m_wvalid = '0; m_wlast = '0; s_wready = 1'b1; s_bvalid = 1'b1;
    #1;
    chk("max_m_bvalid", m_bvalid, 2'b10);
    step();
    s_bvalid = 1'b0;
    #1;
    chk("max_idle_grant", grant, 2'b00);

    // AW backpressure: s_awready low for 5 cycles
    s_awready = 1'b0;
    m_awvalid = 2'b01; m_awaddr[31:0] = 32'h2000; m_awlen[7:0] = 8'd0;
    m_wvalid = 2'b01; m_wlast = 2'b01; m_bready = 2'b01;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_s_awvalid", s_awvalid, 1'b1);
      chk("bp_s_awaddr", s_awaddr, 32'h2000);
      chk("bp_m_awready", m_awready, 2'b00);
      chk("bp_s_wvalid", s_wvalid, 1'b0);
      step();
    end
    s_awready = 1'b1;
    #1;
    chk("bp_m_awready_hs", m_awready, 2'b01);
    step();
    m_awvalid = 2'b00;
    #1;
    chk("bp_data_s_wvalid", s_wvalid, 1'b1);
    chk("bp_data_s_wlast", s_wlast, 1'b1);
    step();
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b1;
    step();
    s_bvalid = 1'b0;

    // async reset in the middle of a 4-beat burst from m1
    m_awvalid = 2'b10; m_awlen[15:8] = 8'd3; m_bready = 2'b10;
    step();
    #1;
    chk("rstmid_grant", grant, 2'b10);
    step();
    m_awvalid = 2'b00;
    for (int b = 0; b < 2; b++) begin
      m_wvalid = 2'b10; m_wlast = 2'b00;
      step();
    end
    #1;
    chk("rstmid_s_wvalid_pre", s_wvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("rstmid_grant_async", grant, 2'b00);
    chk("rstmid_s_wvalid", s_wvalid, 1'b0);
    chk("rstmid_m_wready", m_wready, 2'b00);
    chk("rstmid_s_wlast", s_wlast, 1'b0);
    chk("rstmid_perr", protocol_err, 1'b0);
    step();
    m_wvalid = '0;
    m_awvalid = 2'b11;
    aresetn = 1'b1;
    #1;
    chk("rstmid_grant_release", grant, 2'b00);
    step();
    #1;
    chk("rstmid_regrant_m0", grant, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_write_arbiter.md
# axi4_write_arbiter

Round-robin arbiter that shares one AXI4 slave write port among `NO_OF_MASTERS` write requesters. It sits between the master-side write channels (AW/W/B) and a single downstream slave. One write burst is in flight at a time: a master holds the grant from address acceptance through its last data beat and the write response. The arbiter generates the slave-side `wlast` from the granted `awlen`, and flags any disagreement with the master's own `wlast`.

## Interface
Parameters:
- `NO_OF_MASTERS`, 2: number of requesters (2–16).
- `ADDRESS_WIDTH`, 32: AW address width.
- `DATA_WIDTH`, 32: W data width; strobe width is `DATA_WIDTH/8`.
- `ID_WIDTH`, 4: AWID/BID width.

Ports. Per-master buses are flattened, with master i in slice i. Clock and reset: one clock; reset is asynchronous and active-low.
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `m_awvalid` / `m_awready`  in / out  N  per-master AW handshake.
- `m_awid` / `m_awaddr` / `m_awlen` / `m_awsize` / `m_awburst`  in  N×(ID_WIDTH / ADDRESS_WIDTH / 8 / 3 / 2)  AW payload.
- `m_wvalid` / `m_wready`  in / out  N  W handshake.
- `m_wdata` / `m_wstrb` / `m_wlast`  in  N×(DATA_WIDTH / DATA_WIDTH/8 / 1)  W payload.
- `m_bvalid` / `m_bready`  out / in  N  B handshake.
- `m_bid` / `m_bresp`  out  ID_WIDTH / 2  B payload, shared by all masters and qualified by `m_bvalid`.
- `s_aw*`, `s_w*`, `s_b*`  slave-side mirror of the above, single instance. `s_wlast` is generated by the arbiter.
- `grant`  out  N  one-hot current owner; all zeros in IDLE.
- `protocol_err`  out  1  sticky; set on a `wlast` mismatch.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any `m_awvalid` is set, choose the winner by round-robin, starting the search at `rr_ptr`.
  - Register the winner in `grant` and go to ADDR.
  - `rr_ptr` wraps from N-1 to 0.
- ADDR:
  - `s_aw*` mirrors the granted master's AW signals. `m_awready[g]` = `s_awready`.
  - On an `s_awvalid && s_awready` handshake, load `beats_left` = awlen (8-bit) and go to DATA.
- DATA:
  - `s_w*` mirrors the granted master. `s_wlast` = (`beats_left == 0`). `m_wready[g]` = `s_wready`.
  - On each W handshake: if `m_wlast[g] != s_wlast`, set `protocol_err`. Then:
    - if `beats_left == 0`, go to RESP;
    - otherwise decrement `beats_left`.
- RESP:
  - `m_bvalid[g]` = `s_bvalid`, `s_bready` = `m_bready[g]`, and the B payload passes through.
  - On the B handshake: `rr_ptr` = g+1 (mod N), clear `grant`, go to IDLE.
- Masters without the grant see every ready and `m_bvalid` held at 0.
- Channel signals outside their own state are 0: `s_awvalid` outside ADDR, `s_wvalid` outside DATA, `s_bready` outside RESP.
- `protocol_err` clears only on reset.
- A master whose `awvalid` drops in ADDR simply stalls the arbiter. There is no timeout.

## Timing
- Reset values: state IDLE, `grant` = 0, `rr_ptr` = 0, `beats_left` = 0, `protocol_err` = 0, and every valid/ready output = 0.
- An async assert mid-burst discards the burst immediately. Release is synchronous to `aclk`.
- Arbitration latency: `m_awvalid` rising at edge k gives `grant` and `s_awvalid` at edge k+1. Minimum idle gap between bursts is 1 cycle (the IDLE state).
- Pass-through paths are combinational within a state: valid→valid, ready→ready, payload→payload, with no added pipeline stage.
- Beat count is awlen+1, so awlen = 255 gives 256 beats. `beats_left` decrements only on a handshake, so backpressure never loses or duplicates a beat.
- Simultaneous requests in IDLE: the lowest index at or after `rr_ptr` wins. Requests arriving in ADDR, DATA or RESP wait.
- A B handshake and a new request in the same cycle: IDLE is still entered first; the new grant appears one cycle later using the updated `rr_ptr`.

## Test plan
- Single burst:
  - Stimulus: m0 awaddr=0x100, awlen=3, wdata 0x11..0x44, slave always ready, bresp=OKAY.
  - Response: `grant`=01 one cycle after awvalid; 4 W beats with `s_wlast` on beat 4 only; `m_bvalid[0]` with bresp=00; back to IDLE; `protocol_err`=0.
- Fairness:
  - Stimulus: m0 and m1 both request continuously after reset, awlen=0.
  - Response: grant order m0, m1, m0, m1. `rr_ptr` wraps 1→0.
- Early wlast:
  - Stimulus: awlen=3, master asserts `wlast` on beat 2.
  - Response: `protocol_err`=1 from that cycle and stays 1; `s_wlast` is still asserted on beat 4.
- Max burst:
  - Stimulus: awlen=255 with `s_wready` toggling every cycle.
  - Response: exactly 256 handshakes; `s_wlast` only on the 256th.
- Backpressure:
  - Stimulus: `s_awready` held low for 5 cycles.
  - Response: `s_awvalid` and AW payload stay stable; DATA is entered only after the handshake.
- Reset mid-DATA:
  - Stimulus: `aresetn` low after beat 2 of an awlen=3 burst from m1.
  - Response: all outputs 0 asynchronously. After release, simultaneous m0/m1 requests grant m0 first.
